// File: rtl/controle_exibicao_matriz.sv
// Scan-clock divider, screen alternation and debounced tank-level sensors for the 5x7 matrix.
// Optional blinking of the level outputs while in ERRO is enabled by defining PISCA_ERRO_EN.
module controle_exibicao_matriz #(
    parameter int DIV_SCAN   = 25000,
    parameter int TEMPO_TELA = 500,
    parameter int FILTRO_N   = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic sensor_alta,
    input  logic sensor_media,
    input  logic sensor_baixa,
    output logic frequencia_display,
    output logic seletor,
    output logic Alta,
    output logic Media,
    output logic Baixa,
    output logic erro_sensor
);

    localparam int DW = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
    localparam int TW = (TEMPO_TELA > 1) ? $clog2(TEMPO_TELA) : 1;
    localparam int FW = $clog2(FILTRO_N + 1);

    typedef enum logic [1:0] {
        TELA_IRRIGACAO = 2'd0,
        TELA_CAIXA     = 2'd1,
        ERRO           = 2'd2
    } tela_t;

    logic [DW-1:0] div_cnt;
    logic          div_wrap;
    logic          tick_scan;

    assign div_wrap  = (div_cnt == DW'(DIV_SCAN - 1));
    assign tick_scan = div_wrap && !frequencia_display;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt            <= '0;
            frequencia_display <= 1'b0;
        end else if (div_wrap) begin
            div_cnt            <= '0;
            frequencia_display <= ~frequencia_display;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Two-flop synchroniser; bit order {alta, media, baixa}.
    logic [2:0] sync1;
    logic [2:0] sync2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
        end else begin
            sync1 <= {sensor_alta, sensor_media, sensor_baixa};
            sync2 <= sync1;
        end
    end

    logic [2:0]    cand;
    logic [2:0]    cand_next;
    logic [FW-1:0] cnt;
    logic [FW-1:0] cnt_next;
    logic [2:0]    filt;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cand_next = cand;
        cnt_next  = cnt;
        if (sync2 == cand) begin
            if (cnt != FW'(FILTRO_N))
                cnt_next = cnt + FW'(1);
        end else begin
            cand_next = sync2;
            cnt_next  = FW'(1);
        end
    end

    // The filtered vector follows the candidate on the tick its run reaches FILTRO_N.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cand <= 3'b000;
            cnt  <= '0;
            filt <= 3'b000;
        end else if (tick_scan) begin
            cand <= cand_next;
            cnt  <= cnt_next;
            if (cnt_next == FW'(FILTRO_N))
                filt <= cand_next;
        end
    end

    logic inval;
    assign inval = (filt[2] & ~filt[1]) | (filt[1] & ~filt[0]) | (filt[2] & ~filt[0]);

    tela_t         estado;
    logic [TW-1:0] tela_cnt;

    // Inconsistency is checked first so it overrides a screen timeout on the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado      <= TELA_IRRIGACAO;
            tela_cnt    <= '0;
            seletor     <= 1'b0;
            erro_sensor <= 1'b0;
        end else if (inval) begin
            estado      <= ERRO;
            tela_cnt    <= '0;
            seletor     <= 1'b1;
            erro_sensor <= 1'b1;
        end else begin
            case (estado)
                TELA_IRRIGACAO, TELA_CAIXA: begin
                    if (tick_scan) begin
                        if (tela_cnt == TW'(TEMPO_TELA - 1)) begin
                            estado   <= (estado == TELA_IRRIGACAO) ? TELA_CAIXA : TELA_IRRIGACAO;
                            seletor  <= (estado == TELA_IRRIGACAO);
                            tela_cnt <= '0;
                        end else begin
                            tela_cnt <= tela_cnt + TW'(1);
                        end
                    end
                end
                default: begin
                    estado      <= TELA_CAIXA;
                    tela_cnt    <= '0;
                    seletor     <= 1'b1;
                    erro_sensor <= 1'b0;
                end
            endcase
        end
    end

`ifdef PISCA_ERRO_EN
    logic [TW-1:0] pisca_cnt;
    logic          apagado;

    // Blink phase advances every TEMPO_TELA ticks spent in ERRO; cleared whenever ERRO is left.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pisca_cnt <= '0;
            apagado   <= 1'b0;
        end else if (estado != ERRO) begin
            pisca_cnt <= '0;
            apagado   <= 1'b0;
        end else if (tick_scan) begin
            if (pisca_cnt == TW'(TEMPO_TELA - 1)) begin
                pisca_cnt <= '0;
                apagado   <= ~apagado;
            end else begin
                pisca_cnt <= pisca_cnt + TW'(1);
            end
        end
    end

    assign {Alta, Media, Baixa} = filt & {3{~(apagado && (estado == ERRO))}};
`else
    assign {Alta, Media, Baixa} = filt;
`endif

endmodule

// File: tb/tb_controle_exibicao_matriz.sv
// Randomised bench for controle_exibicao_matriz: a tick-level reference model feeds a
// scoreboard queue that a negedge monitor drains and compares against the DUT outputs.
module tb_controle_exibicao_matriz;

    localparam int DIV   = 2;
    localparam int TEMPO = 4;
    localparam int FN    = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic sensor_alta  = 1'b0;
    logic sensor_media = 1'b0;
    logic sensor_baixa = 1'b0;
    logic frequencia_display, seletor, Alta, Media, Baixa, erro_sensor;

    controle_exibicao_matriz #(
        .DIV_SCAN  (DIV),
        .TEMPO_TELA(TEMPO),
        .FILTRO_N  (FN)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .sensor_alta       (sensor_alta),
        .sensor_media      (sensor_media),
        .sensor_baixa      (sensor_baixa),
        .frequencia_display(frequencia_display),
        .seletor           (seletor),
        .Alta              (Alta),
        .Media             (Media),
        .Baixa             (Baixa),
        .erro_sensor       (erro_sensor)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nome, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got {freq,sel,err,A,M,B}=%b expected %b", nome, $time, got, exp);
        end
    endtask

    // Reference model: screens are counted in ticks, the filter as run lengths of equal samples.
    typedef enum {M_IRRIG, M_CAIXA, M_ERRO} modo_t;

    int         k;
    logic [2:0] hist[$];
    logic [2:0] run_val;
    int         run_len;
    logic [2:0] nivel;
    modo_t      modo;
    int         tela_ticks;
    int         err_ticks;

    logic [5:0] esperado_q[$];

    task automatic model_reset();
        k          = 0;
        hist       = '{3'b000, 3'b000};
        run_val    = 3'b000;
        run_len    = 0;
        nivel      = 3'b000;
        modo       = M_IRRIG;
        tela_ticks = 0;
        err_ticks  = 0;
    endtask

    task automatic model_step(input logic [2:0] raw);
        logic [2:0] s;
        bit         tick;
        bit         inval;
        modo_t      antigo;
        k++;
        hist.push_back(raw);
        s      = hist.pop_front();
        tick   = (k % (2 * DIV)) == DIV;
        inval  = !(nivel inside {3'b000, 3'b001, 3'b011, 3'b111});
        antigo = modo;
        if (inval) begin
            modo       = M_ERRO;
            tela_ticks = 0;
        end else if (modo == M_ERRO) begin
            modo       = M_CAIXA;
            tela_ticks = 0;
        end else if (tick) begin
            tela_ticks++;
            if (tela_ticks == TEMPO) begin
                modo       = (modo == M_IRRIG) ? M_CAIXA : M_IRRIG;
                tela_ticks = 0;
            end
        end
        if (antigo == M_ERRO && tick) err_ticks++;
        if (modo != M_ERRO) err_ticks = 0;
        if (tick) begin
            if (s == run_val) begin
                run_len = (run_len < FN) ? run_len + 1 : FN;
            end else begin
                run_val = s;
                run_len = 1;
            end
            if (run_len == FN) nivel = run_val;
        end
    endtask

    function automatic logic [5:0] esperado();
        logic [2:0] n;
        n = nivel;
`ifdef PISCA_ERRO_EN
        if (modo == M_ERRO && ((err_ticks / TEMPO) % 2) == 1) n = 3'b000;
`endif
        return {1'((k / DIV) % 2), (modo != M_IRRIG), (modo == M_ERRO), n};
    endfunction

    always @(posedge clock) begin
        if (reset) model_reset();
        else       model_step({sensor_alta, sensor_media, sensor_baixa});
        esperado_q.push_back(esperado());
    end

    always @(negedge clock) begin
        if (esperado_q.size() > 0)
            check("saidas", {frequencia_display, seletor, erro_sensor, Alta, Media, Baixa},
                  esperado_q.pop_front());
    end

    task automatic hold(input logic [2:0] v, input int ticks);
        {sensor_alta, sensor_media, sensor_baixa} = v;
        repeat (ticks * 2 * DIV) @(negedge clock);
    endtask

    task automatic pulso_reset();
        @(negedge clock);
        #1 reset = 1'b1;
        #1 check("reset_assincrono",
                 {frequencia_display, seletor, erro_sensor, Alta, Media, Baixa}, 6'b000000);
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        hold(3'b000, 10);
        hold(3'b011, 5);
        hold(3'b111, 1);
        hold(3'b011, 4);
        hold(3'b100, 6);
        hold(3'b111, 8);
        hold(3'b010, 12);
        pulso_reset();
        hold(3'b000, 6);
        repeat (60) begin
            hold(3'($urandom_range(0, 7)), int'($urandom_range(1, 5)));
            if ($urandom_range(0, 19) == 0) pulso_reset();
        end
        repeat (4) @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
